// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting one CPU cache port at a time access to the data-memory port.
// Optional ARB_PERF_COUNT_EN adds per-CPU completed-grant counters on grant_cnt.
module mem_bus_arbiter #(
  parameter int CPUS = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    cdREN,
  input  logic [CPUS-1:0]    cdWEN,
  input  logic [CPUS*32-1:0] cdaddr,
  input  logic [CPUS*32-1:0] cdstore,
  output logic [CPUS-1:0]    cdwait,
  output logic [CPUS*32-1:0] cdload,
  output logic               dREN,
  output logic               dWEN,
  output logic [31:0]        daddr,
  output logic [31:0]        dstore,
  input  logic               dwait,
  input  logic [31:0]        dload
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [CPUS*32-1:0] grant_cnt
`endif
);

  localparam int IW = $clog2(CPUS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [CPUS-1:0] w_req;
  logic            w_any;
  logic            w_req_g;
  logic            w_done;

  assign w_req   = cdREN | cdWEN;
  assign w_any   = |w_req;
  assign w_req_g = w_req[r_grant];
  assign w_done  = (r_state == ACCESS) && w_req_g && !dwait;

  // Search starts one past the last completed grant and wraps.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= CPUS; k++) begin
      int unsigned idx;
      idx = (32'(r_last) + k) % CPUS;
      if (!w_found && w_req[idx]) begin
        w_pick  = IW'(idx);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(CPUS - 1);
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) r_grant <= w_pick;
      if (w_done) r_last <= r_grant;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  if (!w_req_g || !dwait) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    cdwait = '1;
    cdload = '0;
    if (r_state == ACCESS) begin
      daddr  = cdaddr[{r_grant, 5'b0} +: 32];
      dstore = cdstore[{r_grant, 5'b0} +: 32];
      // A withdrawn request keeps the enables low and never signals completion.
      if (w_req_g) begin
        dWEN            = cdWEN[r_grant];
        dREN            = cdREN[r_grant] & ~cdWEN[r_grant];
        cdwait[r_grant] = dwait;
      end
      if (w_done) cdload[{r_grant, 5'b0} +: 32] = dload;
    end
  end

`ifdef ARB_PERF_COUNT_EN
  logic [CPUS*32-1:0] r_grant_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_grant_cnt <= '0;
    end else if (w_done) begin
      r_grant_cnt[{r_grant, 5'b0} +: 32] <= r_grant_cnt[{r_grant, 5'b0} +: 32] + 32'd1;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int N = 2;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    cdREN, cdWEN;
  logic [N*32-1:0] cdaddr, cdstore;
  logic [N-1:0]    cdwait;
  logic [N*32-1:0] cdload;
  logic            dREN, dWEN;
  logic [31:0]     daddr, dstore;
  logic            dwait;
  logic [31:0]     dload;
`ifdef ARB_PERF_COUNT_EN
  logic [N*32-1:0] grant_cnt;
`endif

  mem_bus_arbiter #(.CPUS(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .cdREN(cdREN), .cdWEN(cdWEN), .cdaddr(cdaddr), .cdstore(cdstore),
    .cdwait(cdwait), .cdload(cdload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
`ifdef ARB_PERF_COUNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which CPU owns memory (-1 = arbitrating), who completed last, completion counts.
  int          m_owner = -1;
  int          m_last  = N - 1;
  logic [31:0] m_cnt [N];
  logic [N-1:0] m_done = '0;

  always @(negedge CLK) begin
    logic [N-1:0]    e_wait;
    logic [N*32-1:0] e_load;
    logic            e_ren, e_wen;
    logic [31:0]     e_addr, e_store;
    logic [N-1:0]    req;
    int              g;
    e_wait = '1; e_load = '0; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    m_done = '0;
    req = cdREN | cdWEN;
    g = m_owner;
    if (!nRST) begin
      m_owner = -1;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      g = -1;
    end else if (g >= 0) begin
      e_addr  = cdaddr[g*32 +: 32];
      e_store = cdstore[g*32 +: 32];
      if (req[g]) begin
        e_wen     = cdWEN[g];
        e_ren     = cdREN[g] && !cdWEN[g];
        e_wait[g] = dwait;
        if (!dwait) begin
          e_load[g*32 +: 32] = dload;
          m_done[g] = 1'b1;
        end
      end
    end
    chk("m_dREN", dREN, e_ren);
    chk("m_dWEN", dWEN, e_wen);
    chk("m_daddr", daddr, e_addr);
    chk("m_dstore", dstore, e_store);
    chk("m_cdwait", cdwait, e_wait);
    chk("m_cdload", cdload, e_load);
`ifdef ARB_PERF_COUNT_EN
    for (int i = 0; i < N; i++) chk("m_grant_cnt", grant_cnt[i*32 +: 32], m_cnt[i]);
`endif
    if (nRST) begin
      if (g >= 0) begin
        if (m_done[g]) begin
          m_cnt[g] = m_cnt[g] + 32'd1;
          m_last   = g;
        end
        if (!req[g] || !dwait) m_owner = -1;
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          int c;
          c = (m_last + 1 + k) % N;
          if (req[c]) m_owner = c;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cpu(input int i, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] s);
    cdREN[i] = ren;
    cdWEN[i] = wen;
    cdaddr[i*32 +: 32]  = a;
    cdstore[i*32 +: 32] = s;
  endtask

  logic [N-1:0] pend = '0;

  initial begin
    nRST = 1'b0; cdREN = '0; cdWEN = '0; cdaddr = '0; cdstore = '0;
    dwait = 1'b1; dload = '0;
    @(negedge CLK);
    chk("rst_cdwait", cdwait, 2'b11);
    chk("rst_dREN", dREN, 1'b0);
    chk("rst_cdload", cdload, '0);
    cyc(); nRST = 1'b1;

    // Single read with two extra memory wait cycles.
    cyc(); set_cpu(0, 1, 0, 32'h100, 0); dwait = 1'b1;
    @(negedge CLK); chk("t1_idle_cdwait", cdwait, 2'b11); chk("t1_idle_dREN", dREN, 1'b0);
    cyc();
    @(negedge CLK); chk("t1_acc_dREN", dREN, 1'b1); chk("t1_daddr", daddr, 32'h100);
    chk("t1_acc_cdwait", cdwait, 2'b11);
    cyc();
    cyc(); dwait = 1'b0; dload = 32'hDEADBEEF;
    @(negedge CLK); chk("t1_done_cdwait", cdwait, 2'b10);
    chk("t1_cdload0", cdload[31:0], 32'hDEADBEEF); chk("t1_cdload1", cdload[63:32], 32'h0);
    cyc(); set_cpu(0, 0, 0, 0, 0); dwait = 1'b1;
    @(negedge CLK); chk("t1_after_cdwait", cdwait, 2'b11);

    // Reset in the middle of an access.
    cyc(); set_cpu(1, 1, 0, 32'h80, 0);
    cyc();
    @(negedge CLK); chk("rm_acc_dREN", dREN, 1'b1);
    cyc(); nRST = 1'b0;
    @(negedge CLK); chk("rm_dREN", dREN, 1'b0); chk("rm_dWEN", dWEN, 1'b0);
    chk("rm_daddr", daddr, 32'h0); chk("rm_cdwait", cdwait, 2'b11);

    // Both CPUs requesting continuously: 0,1,0,1.
    cyc(); nRST = 1'b1; set_cpu(0, 1, 0, 32'h10, 0); set_cpu(1, 1, 0, 32'h20, 0);
    dwait = 1'b0; dload = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge CLK);
      chk("rr_cdwait", cdwait, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_daddr", daddr, (k % 2 == 0) ? 32'h10 : 32'h20);
      cyc();
    end
    set_cpu(0, 0, 0, 0, 0); set_cpu(1, 0, 0, 0, 0); dwait = 1'b1;

    // Read and write both set: write wins.
    cyc(); set_cpu(1, 1, 1, 32'h40, 32'hCAFEF00D);
    cyc();
    @(negedge CLK); chk("wr_dWEN", dWEN, 1'b1); chk("wr_dREN", dREN, 1'b0);
    chk("wr_dstore", dstore, 32'hCAFEF00D); chk("wr_daddr", daddr, 32'h40);
    cyc(); dwait = 1'b0;
    @(negedge CLK); chk("wr_done_cdwait", cdwait, 2'b01);
    cyc(); set_cpu(1, 0, 0, 0, 0); dwait = 1'b1;

    // Withdrawn request aborts without moving priority.
    cyc(); set_cpu(0, 1, 0, 32'h200, 0);
    cyc();
    @(negedge CLK); chk("ab_acc_dREN", dREN, 1'b1);
    cyc(); set_cpu(0, 0, 0, 32'h200, 0);
    @(negedge CLK); chk("ab_dREN", dREN, 1'b0); chk("ab_cdwait", cdwait, 2'b11);
    cyc(); set_cpu(0, 1, 0, 32'h300, 0); set_cpu(1, 1, 0, 32'h400, 0); dwait = 1'b0;
    @(negedge CLK); chk("ab_idle_cdwait", cdwait, 2'b11);
    cyc();
    @(negedge CLK); chk("ab_next_cdwait", cdwait, 2'b10); chk("ab_next_daddr", daddr, 32'h300);
    cyc(); set_cpu(0, 0, 0, 0, 0); set_cpu(1, 0, 0, 0, 0); dwait = 1'b1;

    // Randomized traffic; requesters hold their request until completion or withdrawal.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      nRST = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++) begin
        if (!nRST || m_done[i]) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
          set_cpu(i, 0, 0, 0, 0);
        end else if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            logic [1:0] rw;
            rw = 2'($urandom_range(1, 3));
            pend[i] = 1'b1;
            set_cpu(i, rw[0], rw[1], $urandom, $urandom);
          end else begin
            set_cpu(i, 0, 0, 0, 0);
          end
        end
      end
      dwait = 1'($urandom_range(0, 1));
      dload = $urandom;
    end
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
